// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: request side drives operands and start,
// adder side returns the sum, final carry and status.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin,
        input  sum, c_out, busy, done
    );

    modport slave (
        input  start, a, b, cin,
        output sum, c_out, busy, done
    );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: shifts two WIDTH-bit operands LSB first through one full-adder cell,
// holding the carry in a register between bits; sum fills from the MSB end.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_if.slave       bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Single full-adder cell fed from the operand LSBs and the looped-back carry.
    logic fa_a, fa_b, fa_s, fa_co;
    assign fa_a  = a_sh_q[0];
    assign fa_b  = b_sh_q[0];
    assign fa_s  = fa_a ^ fa_b ^ carry_q;
    assign fa_co = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d = fa_co;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                if (count_q == LAST_CNT) begin
                    // Counter parks at its last value rather than wrapping.
                    c_out_d = fa_co;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            count_q <= count_d;
        end
    end

    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed and random checks of serial_adder_seq at WIDTH 8, 16 and 2.
module tb_serial_adder_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int          sel;
    logic        start_r;
    logic [31:0] a_r, b_r;
    logic        cin_r;

    serial_adder_if #(.WIDTH(8))  if8 ();
    serial_adder_if #(.WIDTH(16)) if16 ();
    serial_adder_if #(.WIDTH(2))  if2 ();

    serial_adder_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_adder_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    serial_adder_seq #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(if2.slave));

    assign if8.start  = start_r && (sel == 0);
    assign if8.a      = a_r[7:0];
    assign if8.b      = b_r[7:0];
    assign if8.cin    = cin_r;
    assign if16.start = start_r && (sel == 1);
    assign if16.a     = a_r[15:0];
    assign if16.b     = b_r[15:0];
    assign if16.cin   = cin_r;
    assign if2.start  = start_r && (sel == 2);
    assign if2.a      = a_r[1:0];
    assign if2.b      = b_r[1:0];
    assign if2.cin    = cin_r;

    logic [31:0] o_sum;
    logic        o_c, o_busy, o_done;
    always_comb begin
        o_sum  = '0;
        o_c    = 1'b0;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (sel)
            0: begin o_sum = 32'(if8.sum);  o_c = if8.c_out;  o_busy = if8.busy;  o_done = if8.done;  end
            1: begin o_sum = 32'(if16.sum); o_c = if16.c_out; o_busy = if16.busy; o_done = if16.done; end
            default: begin o_sum = 32'(if2.sum); o_c = if2.c_out; o_busy = if2.busy; o_done = if2.done; end
        endcase
    end

    int total_cnt = 0;
    int fail_cnt  = 0;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cur_width();
        return (sel == 0) ? 8 : (sel == 1) ? 16 : 2;
    endfunction

    // One full transaction: accept, count busy cycles, check latency, result and pulse width.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [31:0] exp_sum, input logic exp_c, input string tag);
        int   w;
        int   cyc;
        int   bc;
        logic overlap;
        w = cur_width();
        a_r = a; b_r = b; cin_r = c; start_r = 1'b1;
        tick();
        start_r = 1'b0;
        cyc = 1; bc = 0; overlap = 1'b0;
        while (!o_done && cyc < 100) begin
            if (o_busy) bc++;
            tick();
            cyc++;
        end
        overlap = o_busy & o_done;
        check({tag, "_latency"}, 33'(cyc), 33'(w + 1));
        check({tag, "_busy_cycles"}, 33'(bc), 33'(w));
        check({tag, "_sum"}, 33'(o_sum), 33'(exp_sum));
        check({tag, "_c_out"}, 33'(o_c), 33'(exp_c));
        check({tag, "_busy_done_overlap"}, 33'(overlap), 33'(0));
        $display("W%0d %s a=%0h b=%0h cin=%0b -> sum=%0h c_out=%0b (exp %0h/%0b)",
                 w, tag, a, b, c, o_sum, o_c, exp_sum, exp_c);
        tick();
        check({tag, "_done_width"}, 33'(o_done), 33'(0));
    endtask

    initial begin
        int          cyc, prev, dcnt, dcyc, guard;
        logic [31:0] s_cap, mask, ra, rb;
        logic        c_cap, rc;
        logic [32:0] tot;
        logic [31:0] bb_a [4];
        logic [31:0] bb_b [4];
        logic        bb_c [4];
        logic [31:0] bb_s [4];
        logic        bb_co[4];

        sel = 0; start_r = 1'b0; a_r = '0; b_r = '0; cin_r = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_sum", 33'(o_sum), 33'(0));
        check("rst_c_out", 33'(o_c), 33'(0));
        check("rst_busy", 33'(o_busy), 33'(0));
        check("rst_done", 33'(o_done), 33'(0));
        tick();
        rst = 1'b0;
        tick();

        run_op(32'h00, 32'h00, 1'b0, 32'h00, 1'b0, "zero");
        run_op(32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, "ff_plus_1");
        run_op(32'hA5, 32'h5A, 1'b1, 32'h00, 1'b1, "a5_5a_cin");

        // Start pulsed again during RUN cycle 3 must be ignored.
        a_r = 32'h3C; b_r = 32'h42; cin_r = 1'b0; start_r = 1'b1;
        tick();
        start_r = 1'b0;
        tick();
        tick();
        a_r = 32'hFF; b_r = 32'hFF; start_r = 1'b1;
        tick();
        start_r = 1'b0;
        cyc = 4; dcnt = 0; dcyc = 0; s_cap = '0; c_cap = 1'b0;
        repeat (26) begin
            if (o_done) begin
                dcnt++; dcyc = cyc; s_cap = o_sum; c_cap = o_c;
            end
            tick();
            cyc++;
        end
        check("ignored_start_done_count", 33'(dcnt), 33'(1));
        check("ignored_start_done_cycle", 33'(dcyc), 33'(9));
        check("ignored_start_sum", 33'(s_cap), 33'(32'h7E));
        check("ignored_start_c_out", 33'(c_cap), 33'(0));
        $display("W8 ignored_start a=3c b=42 -> sum=%0h c_out=%0b done_pulses=%0d", s_cap, c_cap, dcnt);

        // Reset in RUN cycle 4 aborts with no done pulse.
        a_r = 32'hFF; b_r = 32'hFF; cin_r = 1'b0; start_r = 1'b1;
        tick();
        start_r = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_sum", 33'(o_sum), 33'(0));
        check("abort_c_out", 33'(o_c), 33'(0));
        check("abort_busy", 33'(o_busy), 33'(0));
        dcnt = 0;
        repeat (12) begin
            if (o_done) dcnt++;
            tick();
        end
        check("abort_no_done", 33'(dcnt), 33'(0));
        $display("W8 abort a=ff b=ff -> sum=%0h c_out=%0b busy=%0b", o_sum, o_c, o_busy);
        run_op(32'h01, 32'h01, 1'b0, 32'h02, 1'b0, "after_abort");

        // Start held high, new operands presented in each DONE cycle.
        bb_a[0] = 32'h12; bb_b[0] = 32'h34; bb_c[0] = 1'b0; bb_s[0] = 32'h46; bb_co[0] = 1'b0;
        bb_a[1] = 32'hF0; bb_b[1] = 32'h0F; bb_c[1] = 1'b1; bb_s[1] = 32'h00; bb_co[1] = 1'b1;
        bb_a[2] = 32'h80; bb_b[2] = 32'h80; bb_c[2] = 1'b0; bb_s[2] = 32'h00; bb_co[2] = 1'b1;
        bb_a[3] = 32'h7F; bb_b[3] = 32'h01; bb_c[3] = 1'b1; bb_s[3] = 32'h81; bb_co[3] = 1'b0;
        a_r = bb_a[0]; b_r = bb_b[0]; cin_r = bb_c[0]; start_r = 1'b1;
        tick();
        cyc = 1; prev = 0;
        for (int k = 0; k < 4; k++) begin
            guard = 0;
            while (!o_done && guard < 30) begin
                tick(); cyc++; guard++;
            end
            check("b2b_sum", 33'(o_sum), 33'(bb_s[k]));
            check("b2b_c_out", 33'(o_c), 33'(bb_co[k]));
            check("b2b_interval", 33'(cyc - prev), 33'((k == 0) ? 9 : 10));
            $display("W8 b2b[%0d] a=%0h b=%0h cin=%0b -> sum=%0h c_out=%0b at cycle %0d",
                     k, bb_a[k], bb_b[k], bb_c[k], o_sum, o_c, cyc);
            prev = cyc;
            if (k < 3) begin
                a_r = bb_a[k+1]; b_r = bb_b[k+1]; cin_r = bb_c[k+1];
            end else begin
                start_r = 1'b0;
            end
            tick(); cyc++;
        end
        tick();
        check("b2b_idle_after_release", 33'(o_busy), 33'(0));

        // Random sweeps at the other widths.
        for (int s = 1; s <= 2; s++) begin
            sel = s;
            mask = (s == 1) ? 32'h0000_FFFF : 32'h0000_0003;
            for (int i = 0; i < 1000; i++) begin
                ra  = $urandom & mask;
                rb  = $urandom & mask;
                rc  = 1'($urandom_range(0, 1));
                tot = {1'b0, ra} + {1'b0, rb} + 33'(rc);
                run_op(ra, rb, rc, tot[31:0] & mask, tot[cur_width()], "rand");
            end
        end

        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/serial_adder_seq.md
# serial_adder_seq

Bit-serial adder that sequences two WIDTH-bit operands, LSB first, through a single 1-bit full-adder cell (S = A^B^C, carry-out = majority(A,B,C)). A registered carry loop-back is held between bits. The block sits directly upstream of the full-adder cell: it supplies A, B and C each cycle and captures S and the carry-out. It produces a WIDTH-bit sum plus final carry, trading latency for area against a ripple adder.

## Interface
Parameters:
- WIDTH, 8: operand width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- sum  output  WIDTH  result; valid from the DONE cycle until the next accepted start.
- c_out  output  1  final carry; same validity as sum.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse marking sum/c_out valid.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with start=1, load a_sh<=a, b_sh<=b, carry<=cin and bit count<=0, then go to RUN.
  - start=0: stay in IDLE.
- RUN: each edge processes one bit.
  - Full-adder cell inputs: A=a_sh[0], B=b_sh[0], C=carry.
  - carry <= cell carry-out.
  - a_sh and b_sh shift right by 1.
  - sum shifts right with S entering at bit WIDTH-1.
  - count increments.
  - On the edge where count==WIDTH-1, go to DONE and load c_out <= cell carry-out.
- DONE: lasts exactly one cycle, then IDLE unconditionally.
- sum and c_out are not updated during IDLE or DONE. They hold the last result until the next accepted start. They are cleared only by rst.
- During RUN, sum holds partially shifted data and is not valid.
- Arithmetic: {c_out, sum} == a + b + cin (unsigned, WIDTH+1 bits). No overflow flag.
- start while in RUN or DONE is ignored and is not queued. a, b and cin are don't-care outside the accepting edge.
- Bit counter width: clog2(WIDTH). It never wraps past WIDTH-1.

## Timing
- Reset values, effective on the first edge with rst=1: state=IDLE, sum=0, c_out=0, busy=0, done=0, count=0, carry=0, a_sh=0, b_sh=0.
- rst has priority over all other inputs in every state.
- Reset mid-RUN aborts the operation. Outputs take their reset values on that edge; no done pulse follows.
- busy and done are decoded from state (registered state, no combinational path from start):
  - busy=1 iff RUN.
  - done=1 iff DONE.
- Latency: start accepted at edge 0 → busy high for cycles 1..WIDTH → done high in cycle WIDTH+1 → idle in cycle WIDTH+2.
- Minimum issue interval is WIDTH+2 cycles. A start held high continuously restarts on the first IDLE cycle after DONE.
- busy and done are never high simultaneously.

## Test plan
- Reset then a=8'h00, b=8'h00, cin=0, start pulse → done in cycle 9 after the accepting edge; sum=8'h00, c_out=0; busy high for exactly 8 cycles.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, c_out=1. Then a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, c_out=1.
- a=8'h3C, b=8'h42, cin=0; pulse start again at RUN cycle 3 with a=8'hFF, b=8'hFF → ignored; sum=8'h7E, c_out=0; exactly one done pulse.
- Assert rst during RUN cycle 4 of a=8'hFF + b=8'hFF → next cycle sum=0, c_out=0, busy=0; no done pulse; subsequent 8'h01+8'h01 gives sum=8'h02.
- start held high continuously, operands changed every DONE cycle → back-to-back results every 10 cycles, each matching a+b+cin.
- WIDTH=16 and WIDTH=2: 1000 random operand/cin sets compared against a+b+cin; done pulse width exactly 1 cycle each time.
